// File: rtl/mult_pkg.sv
// Shared state encoding and sizing helpers for the sequential arithmetic unit
// (multiplier and divider control use the same state type).
package mult_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mult_state_t;

  localparam int C_NUM_BITS_DEF = 4;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mult_ctrl.sv
// Multiplier sequencer: accepts START in IDLE/DONE, runs exactly N enabled
// iterations, then presents DONE for one enabled cycle.
//  state  | meaning
//  S_IDLE | waiting for START
//  S_RUN  | one shift-add iteration per enabled clock, N in total
//  S_DONE | product just written; VALID high, START accepted back-to-back
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int N = C_NUM_BITS_DEF
) (
  input  logic ck,
  input  logic rn,
  input  logic e,
  input  logic start,
  output logic load,
  output logic step,
  output logic done,
  output logic busy,
  output logic valid
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  mult_state_t state;
  logic [CW-1:0] cnt;

  assign load  = e && start && ((state == S_IDLE) || (state == S_DONE));
  assign step  = e && (state == S_RUN);
  assign done  = step && (cnt == CNT_LAST);
  assign busy  = (state == S_RUN);
  assign valid = (state == S_DONE);

  always_ff @(posedge ck) begin
    if (!rn) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (e) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) state <= S_DONE;
        end
        S_DONE: begin
          if (start) begin
            state <= S_RUN;
            cnt   <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier, one multiplier bit per enabled
// clock; the datapath lives here, sequencing in mult_ctrl.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int C_NUM_BITS = C_NUM_BITS_DEF
) (
  input  logic                    CK,
  input  logic                    RN,
  input  logic                    E,
  input  logic                    START,
  input  logic [C_NUM_BITS-1:0]   A,
  input  logic [C_NUM_BITS-1:0]   B,
  output logic [2*C_NUM_BITS-1:0] P,
  output logic                    BUSY,
  output logic                    VALID
);

  localparam int N = C_NUM_BITS;

  logic         load, step, done;
  logic [N-1:0] m;
  logic [2*N:0] acc;
  logic [N:0]   sum;
  logic [2*N:0] acc_next;

  mult_ctrl #(.N(N)) u_ctrl (
    .ck    (CK),
    .rn    (RN),
    .e     (E),
    .start (START),
    .load  (load),
    .step  (step),
    .done  (done),
    .busy  (BUSY),
    .valid (VALID)
  );

  // Upper N+1 bits hold the partial sum with carry; lower N bits are the
  // multiplier bits not yet consumed, so ACC[0] is always the current bit.
  assign sum      = acc[2*N:N] + (acc[0] ? {1'b0, m} : '0);
  assign acc_next = {1'b0, sum, acc[N-1:1]};

  always_ff @(posedge CK) begin
    if (!RN) begin
      m   <= '0;
      acc <= '0;
      P   <= '0;
    end else if (load) begin
      m   <= A;
      acc <= {{(N+1){1'b0}}, B};
    end else if (step) begin
      acc <= acc_next;
      if (done) P <= acc_next[2*N-1:0];
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier (N=4): stimulus pushes expected
// products into a queue, a negedge monitor pops one per enabled VALID cycle.
module tb_shift_add_multiplier;

  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       E = 1'b1;
  logic       START = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic [7:0] P;
  logic       BUSY;
  logic       VALID;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb_q[$];

  shift_add_multiplier #(.C_NUM_BITS(4)) dut (
    .CK    (CK),
    .RN    (RN),
    .E     (E),
    .START (START),
    .A     (A),
    .B     (B),
    .P     (P),
    .BUSY  (BUSY),
    .VALID (VALID)
  );

  always #5 CK = ~CK;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // monitor: one scoreboard pop per enabled DONE cycle
  always @(negedge CK) begin
    if (RN && VALID && E) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_valid: got P=0x%0h with no product pending", P);
      end else begin
        logic [7:0] exp_p;
        exp_p = sb_q.pop_front();
        if (P !== exp_p) begin
          fails++;
          $display("FAIL product: got 0x%0h expected 0x%0h", P, exp_p);
        end
      end
    end
    if (BUSY && VALID) begin
      tests++;
      fails++;
      $display("FAIL busy_valid_overlap: got BUSY=1 VALID=1 expected never both");
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    sb_q.push_back(8'(a) * 8'(b));
    A = a;
    B = b;
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic wait_valid(output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    while (!VALID && n < 40) begin
      if (BUSY) busy_cnt++;
      tick();
      n++;
    end
  endtask

  int n, bc, n2, bc2;

  initial begin
    // reset
    RN = 1'b0;
    E  = 1'b1;
    tick();
    tick();
    check("reset_p", P, 0);
    check("reset_busy", BUSY, 0);
    check("reset_valid", VALID, 0);
    RN = 1'b1;
    tick();

    // 1: 15*15, latency
    issue(4'd15, 4'd15);
    check("t1_busy_after_start", BUSY, 1);
    wait_valid(n, bc);
    check("t1_latency", n, 4);
    check("t1_p", P, 8'hE1);
    tick();
    check("t1_valid_one_cycle", VALID, 0);
    check("t1_p_hold", P, 8'hE1);

    // 2: zero multiplicand still takes N cycles
    issue(4'd0, 4'd9);
    wait_valid(n, bc);
    check("t2_busy_cycles", bc, 4);
    check("t2_latency", n, 4);
    tick();
    tick();
    tick();
    check("t2_p_idle_hold", P, 8'h00);
    check("t2_valid_low_idle", VALID, 0);

    // 3: enable stall in RUN
    issue(4'd7, 4'd6);
    tick();
    E = 1'b0;
    tick();
    tick();
    tick();
    check("t3_frozen_busy", BUSY, 1);
    check("t3_frozen_valid", VALID, 0);
    E = 1'b1;
    wait_valid(n, bc);
    check("t3_latency", n + 4, 7);
    check("t3_p", P, 8'h2A);
    tick();

    // 4: START while busy is ignored
    issue(4'd3, 4'd5);
    A = 4'd15;
    B = 4'd15;
    START = 1'b1;
    tick();
    tick();
    START = 1'b0;
    wait_valid(n, bc);
    check("t4_latency", n + 2, 4);
    check("t4_p", P, 8'h0F);
    tick();
    check("t4_single_valid", VALID, 0);
    tick();

    // 5: back-to-back start from DONE
    issue(4'd5, 4'd5);
    wait_valid(n, bc);
    check("t5a_p", P, 8'h19);
    issue(4'd2, 4'd9);
    check("t5_no_idle_gap", BUSY, 1);
    check("t5_p_held_during_run", P, 8'h19);
    wait_valid(n2, bc2);
    check("t5b_latency", n2, 4);
    check("t5b_p", P, 8'h12);
    tick();

    // 6: reset aborts an operation
    A = 4'd13;
    B = 4'd11;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    RN = 1'b0;
    tick();
    RN = 1'b1;
    check("t6_busy_after_reset", BUSY, 0);
    check("t6_valid_after_reset", VALID, 0);
    check("t6_p_after_reset", P, 0);
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      if (VALID) bc++;
      tick();
    end
    check("t6_no_valid", bc, 0);
    issue(4'd1, 4'd1);
    wait_valid(n, bc);
    check("t6_latency", n, 4);
    check("t6_p", P, 8'h01);
    tick();
    tick();

    check("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
